mul_result_combine: RTL and testbench
=====================================

Name: mul_result_combine

Overview:
- Downstream stage of the Nios II 32x32 multiplier cell.
- Consumes the four registered 16x16 partial products (p1=lo1*lo2, p2=lo1*hi2, p3=hi1*lo2, p4=hi1*hi2) and sums them into the 64-bit product.
- Selects the upper or lower 32 bits and delivers the result with its destination register number to writeback.
- Two-stage pipeline that advances only on M_en and supports flush.

Parameters:
- DST_W, 5, width of destination register number.
- RESULT_W, 32, width of delivered result; must equal half of the 64-bit product width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- M_en  in  1  pipeline advance enable; same enable that clocks the multiplier cell.
- flush  in  1  kills in-flight multiply results.
- M_mul_valid  in  1  partial products on p1..p4 belong to a live multiply instruction.
- M_mul_hi  in  1  1 = deliver product[63:32] (mulh/mulhsu/mulhu); 0 = product[31:0] (mul).
- M_mul_src1_signed  in  1  src1 signed flag, aligned with the partial products.
- M_mul_src2_signed  in  1  src2 signed flag, aligned with the partial products.
- M_dst_regnum  in  DST_W  destination register of the multiply.
- M_mul_cell_p1  in  32  lo1*lo2, unsigned.
- M_mul_cell_p2  in  32  lo1*hi2, signed iff src2 signed.
- M_mul_cell_p3  in  32  hi1*lo2, signed iff src1 signed.
- M_mul_cell_p4  in  32  hi1*hi2, two's complement if either source signed.
- W_mul_valid  out  1  W_mul_result holds a valid result.
- W_mul_result  out  RESULT_W  selected half of the product.
- W_dst_regnum  out  DST_W  destination register paired with W_mul_result.

Behaviour:
- Reset: when reset=1 at a clock edge, all stage registers clear to 0. W_mul_valid=0, W_mul_result=0, W_dst_regnum=0. Reset overrides M_en and flush.
- Stage A, on edge with M_en=1:
  - mid = ext(p2) + ext(p3), 34-bit signed.
  - ext(p2) sign-extends iff M_mul_src2_signed, else zero-extends.
  - ext(p3) sign-extends iff M_mul_src1_signed, else zero-extends.
  - Register mid, p1, p4, M_mul_hi, M_dst_regnum.
  - A_valid <= M_mul_valid & ~flush.
- Stage W, on edge with M_en=1:
  - prod[63:0] = {p4_A, p1_A} + (sign-extend-64(mid_A) << 16), modulo 2^64.
  - W_mul_result <= hi_A ? prod[63:32] : prod[31:0].
  - W_dst_regnum <= dst_A.
  - W_mul_valid <= A_valid & ~flush.
- p4 needs no extension; it occupies bits 63:32 exactly.
- Latency: result appears on W outputs after 2 M_en-qualified edges past partial-product presentation. Throughput is 1 per M_en cycle.
- M_en=0: both stages hold all registers, including valids. Outputs are stable.
- flush=1 with M_en=1: both valids clear. Data registers still load but are don't-care.
- flush=1 with M_en=0: A_valid and W_mul_valid clear; data held.
- M_mul_valid=0 with M_en=1: A_valid loads 0 (bubble). Data paths may load freely.
- Back-to-back ops: no interlock or hazard; each M_en edge shifts one entry.
- Mixed-sign combos: uu, su, us, ss must all give the exact 64-bit two's-complement / unsigned product.

Test Plan:
- Unsigned 0xFFFFFFFF*0xFFFFFFFF: drive p1=p2=p3=p4=0xFFFE0001, signed=0/0, M_en=1 → after 2 edges W_mul_valid=1. hi=1 gives 0xFFFFFFFE; hi=0 gives 0x00000001.
- Signed -1*-1: drive p1=0xFFFE0001, p2=p3=0xFFFF0001, p4=0x00000001, signed=1/1 → hi gives 0x00000000; lo gives 0x00000001.
- mulhsu (-2)*0x80000000: drive p1=0, p2=0x7FFF0000, p3=0, p4=0xFFFF8000, src1_signed=1, src2_signed=0, hi=1 → W_mul_result=0xFFFFFFFF, W_dst_regnum matches input.
- Stall: valid op in stage A, then M_en=0 for 3 cycles → W outputs unchanged. On the 4th cycle M_en=1, the result appears on the next edge.
- Flush: two back-to-back valid ops in flight, pulse flush=1 for 1 cycle with M_en=1 → W_mul_valid=0 on that edge and the following edge. A new op issued after flush emerges 2 edges later.
- Reset mid-operation: valid op in stage A, assert reset=1 for 1 cycle with M_en=1 → W_mul_valid=0, W_mul_result=0, W_dst_regnum=0. No stale result appears afterward.

Source files
------------

// File: rtl/mul_result_combine_if.sv
// Bundle between the multiplier cell's M stage and the W-stage writeback of
// the combined 32x32 product.
interface mul_result_combine_if #(
  parameter int DST_W    = 5,
  parameter int RESULT_W = 32
);
  logic                M_en;
  logic                flush;
  logic                M_mul_valid;
  logic                M_mul_hi;
  logic                M_mul_src1_signed;
  logic                M_mul_src2_signed;
  logic [DST_W-1:0]    M_dst_regnum;
  logic [31:0]         M_mul_cell_p1;
  logic [31:0]         M_mul_cell_p2;
  logic [31:0]         M_mul_cell_p3;
  logic [31:0]         M_mul_cell_p4;
  logic                W_mul_valid;
  logic [RESULT_W-1:0] W_mul_result;
  logic [DST_W-1:0]    W_dst_regnum;

  modport master (
    output M_en, flush, M_mul_valid, M_mul_hi,
    output M_mul_src1_signed, M_mul_src2_signed, M_dst_regnum,
    output M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3, M_mul_cell_p4,
    input  W_mul_valid, W_mul_result, W_dst_regnum
  );

  modport slave (
    input  M_en, flush, M_mul_valid, M_mul_hi,
    input  M_mul_src1_signed, M_mul_src2_signed, M_dst_regnum,
    input  M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3, M_mul_cell_p4,
    output W_mul_valid, W_mul_result, W_dst_regnum
  );
endinterface

// File: rtl/mul_result_combine.sv
// Sums the four 16x16 partial products of the multiplier cell into the 64-bit
// product over two M_en-qualified stages and delivers the selected half.
module mul_result_combine #(
  parameter int DST_W    = 5,
  parameter int RESULT_W = 32
) (
  input logic                clk,
  input logic                reset,
  mul_result_combine_if.slave bus
);

  localparam int PROD_W = 2 * RESULT_W;

  logic [33:0]         mid_next;
  logic [33:0]         mid_a;
  logic [31:0]         p1_a;
  logic [31:0]         p4_a;
  logic                hi_a;
  logic [DST_W-1:0]    dst_a;
  logic                a_valid;
  logic [PROD_W-1:0]   prod;
  logic                w_valid;
  logic [RESULT_W-1:0] w_result;
  logic [DST_W-1:0]    w_dst;

  // The cross terms carry the sign of whichever source contributed the high half.
  always_comb begin
    mid_next = {{2{bus.M_mul_src2_signed & bus.M_mul_cell_p2[31]}}, bus.M_mul_cell_p2}
             + {{2{bus.M_mul_src1_signed & bus.M_mul_cell_p3[31]}}, bus.M_mul_cell_p3};
  end

  always_comb begin
    prod = {p4_a, p1_a} + ({{(PROD_W-34){mid_a[33]}}, mid_a} << 16);
  end

  // Flush kills valids even while stalled; data registers only move on M_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      mid_a    <= '0;
      p1_a     <= '0;
      p4_a     <= '0;
      hi_a     <= 1'b0;
      dst_a    <= '0;
      a_valid  <= 1'b0;
      w_valid  <= 1'b0;
      w_result <= '0;
      w_dst    <= '0;
    end else if (bus.M_en) begin
      mid_a    <= mid_next;
      p1_a     <= bus.M_mul_cell_p1;
      p4_a     <= bus.M_mul_cell_p4;
      hi_a     <= bus.M_mul_hi;
      dst_a    <= bus.M_dst_regnum;
      a_valid  <= bus.M_mul_valid & ~bus.flush;
      w_valid  <= a_valid & ~bus.flush;
      w_result <= hi_a ? prod[PROD_W-1:RESULT_W] : prod[RESULT_W-1:0];
      w_dst    <= dst_a;
    end else if (bus.flush) begin
      a_valid  <= 1'b0;
      w_valid  <= 1'b0;
    end
  end

  assign bus.W_mul_valid  = w_valid;
  assign bus.W_mul_result = w_result;
  assign bus.W_dst_regnum = w_dst;

endmodule

// File: tb/tb_mul_result_combine.sv
// Self-checking bench for mul_result_combine: constant vector table and random
// ops through a scoreboard, plus hand-written stall/flush/reset sequences.
module tb_mul_result_combine;

  localparam int DST_W    = 5;
  localparam int RESULT_W = 32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s1;
    logic        s2;
    logic        hi;
    logic [4:0]  dst;
    logic [31:0] exp_res;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dst;
    int          due;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;
  bit   mon_en   = 1'b0;
  sb_t  exp_q[$];
  sb_t  mon_e;
  vec_t vecs[15];

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  mul_result_combine_if #(.DST_W(DST_W), .RESULT_W(RESULT_W)) bus ();

  mul_result_combine #(.DST_W(DST_W), .RESULT_W(RESULT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Reference: full-width multiply of the extended operands, modulo 2^64.
  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b,
                                              input logic s1, input logic s2);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {{32{s1 & a[31]}}, a};
    eb = {{32{s2 & b[31]}}, b};
    return ea * eb;
  endfunction

  // Plays the multiplier cell: split operands into halves and form the four products.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic s1, input logic s2, input logic hi,
                               input logic [4:0] dst, input logic valid,
                               input logic en, input logic fl);
    logic [31:0] lo1e, hi1e, lo2e, hi2e;
    lo1e = {16'b0, a[15:0]};
    lo2e = {16'b0, b[15:0]};
    hi1e = {{16{s1 & a[31]}}, a[31:16]};
    hi2e = {{16{s2 & b[31]}}, b[31:16]};
    bus.M_mul_cell_p1     = lo1e * lo2e;
    bus.M_mul_cell_p2     = lo1e * hi2e;
    bus.M_mul_cell_p3     = hi1e * lo2e;
    bus.M_mul_cell_p4     = hi1e * hi2e;
    bus.M_mul_src1_signed = s1;
    bus.M_mul_src2_signed = s2;
    bus.M_mul_hi          = hi;
    bus.M_dst_regnum      = dst;
    bus.M_mul_valid       = valid;
    bus.M_en              = en;
    bus.flush             = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic s1,
                         input logic s2, input logic hi, input logic [4:0] dst,
                         input logic [31:0] exp_res);
    sb_t e;
    applyStimulus(a, b, s1, s2, hi, dst, 1'b1, 1'b1, 1'b0);
    e.res = exp_res;
    e.dst = dst;
    e.due = cycle + 2;
    exp_q.push_back(e);
    step();
  endtask

  task automatic bubble(input logic en, input logic fl);
    applyStimulus(32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 5'd31, 1'b0, en, fl);
  endtask

  // Stream monitor: every valid W beat must match the oldest expected entry on time.
  always @(negedge clk) begin
    if (mon_en && bus.W_mul_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL stream_unexpected actual=0x%0h expected=none", bus.W_mul_result);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("stream_result", 64'(bus.W_mul_result), 64'(mon_e.res));
        checkOutput("stream_dst", 64'(bus.W_dst_regnum), 64'(mon_e.dst));
        checkOutput("stream_latency", 64'(cycle), 64'(mon_e.due));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs1, rs2, rhi;
    logic [4:0]  rdst;
    logic [63:0] rp;

    vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 5'd1,  32'hFFFFFFFE};
    vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 5'd2,  32'h00000001};
    vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 5'd3,  32'h00000000};
    vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 5'd4,  32'h00000001};
    vecs[4]  = '{32'hFFFFFFFE, 32'h80000000, 1'b1, 1'b0, 1'b1, 5'd5,  32'hFFFFFFFF};
    vecs[5]  = '{32'h00000003, 32'hFFFFFFFB, 1'b0, 1'b1, 1'b1, 5'd6,  32'hFFFFFFFF};
    vecs[6]  = '{32'h00000003, 32'hFFFFFFFB, 1'b0, 1'b1, 1'b0, 5'd7,  32'hFFFFFFF1};
    vecs[7]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 5'd8,  32'h40000000};
    vecs[8]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 5'd10, 32'hFFFFFFFF};
    vecs[9]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 5'd11, 32'h80000000};
    vecs[10] = '{32'h00010000, 32'h00010000, 1'b0, 1'b0, 1'b1, 5'd12, 32'h00000001};
    vecs[11] = '{32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b1, 1'b0, 5'd13, 32'hFFFFFFFE};
    vecs[12] = '{32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b1, 1'b1, 5'd14, 32'hFFFFFFFF};
    vecs[13] = '{32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b0, 1'b1, 5'd15, 32'h00000001};
    vecs[14] = '{32'h00000000, 32'h12345678, 1'b1, 1'b1, 1'b1, 5'd16, 32'h00000000};

    reset = 1'b1;
    bubble(1'b0, 1'b0);
    step();
    step();
    checkOutput("reset_valid", 64'(bus.W_mul_valid), 64'd0);
    checkOutput("reset_result", 64'(bus.W_mul_result), 64'd0);
    checkOutput("reset_dst", 64'(bus.W_dst_regnum), 64'd0);
    reset = 1'b0;

    $display("[TB] table vectors");
    mon_en = 1'b1;
    for (int i = 0; i < 15; i++)
      push_op(vecs[i].a, vecs[i].b, vecs[i].s1, vecs[i].s2, vecs[i].hi, vecs[i].dst,
              vecs[i].exp_res);

    $display("[TB] random ops with bubbles");
    for (int i = 0; i < 40; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rs1  = 1'($urandom_range(0, 1));
      rs2  = 1'($urandom_range(0, 1));
      rhi  = 1'($urandom_range(0, 1));
      rdst = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) begin
        bubble(1'b1, 1'b0);
        step();
      end else begin
        rp = ref_product(ra, rb, rs1, rs2);
        push_op(ra, rb, rs1, rs2, rhi, rdst, rhi ? rp[63:32] : rp[31:0]);
      end
    end
    bubble(1'b1, 1'b0);
    repeat (3) step();
    checkOutput("stream_drain", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;

    $display("[TB] stall sequence");
    step();
    checkOutput("stall_pre_valid", 64'(bus.W_mul_valid), 64'd0);
    applyStimulus(32'h00000007, 32'hFFFFFFFA, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h13579BDF, 32'h2468ACE0, 1'b0, 1'b0, 1'b1, 5'd30, 1'b1, 1'b0, 1'b0);
      step();
      checkOutput("stall_hold_valid", 64'(bus.W_mul_valid), 64'd0);
    end
    bubble(1'b1, 1'b0);
    step();
    checkOutput("stall_valid", 64'(bus.W_mul_valid), 64'd1);
    checkOutput("stall_result", 64'(bus.W_mul_result), 64'hFFFFFFD6);
    checkOutput("stall_dst", 64'(bus.W_dst_regnum), 64'd9);
    applyStimulus(32'h13579BDF, 32'h2468ACE0, 1'b0, 1'b0, 1'b1, 5'd30, 1'b1, 1'b0, 1'b0);
    step();
    step();
    checkOutput("stall_w_hold_valid", 64'(bus.W_mul_valid), 64'd1);
    checkOutput("stall_w_hold_result", 64'(bus.W_mul_result), 64'hFFFFFFD6);

    $display("[TB] flush sequence");
    applyStimulus(32'd5, 32'd6, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0);
    step();
    applyStimulus(32'd8, 32'd9, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("flush_pre_result", 64'(bus.W_mul_result), 64'd30);
    applyStimulus(32'd10, 32'd11, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1);
    step();
    checkOutput("flush_edge_valid", 64'(bus.W_mul_valid), 64'd0);
    bubble(1'b1, 1'b0);
    step();
    checkOutput("flush_next_valid", 64'(bus.W_mul_valid), 64'd0);
    applyStimulus(32'h100, 32'h100, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("flush_gap_valid", 64'(bus.W_mul_valid), 64'd0);
    bubble(1'b1, 1'b0);
    step();
    checkOutput("flush_after_valid", 64'(bus.W_mul_valid), 64'd1);
    checkOutput("flush_after_result", 64'(bus.W_mul_result), 64'h10000);
    checkOutput("flush_after_dst", 64'(bus.W_dst_regnum), 64'd7);

    applyStimulus(32'd3, 32'd3, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    step();
    applyStimulus(32'd4, 32'd4, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("flush_stall_pre_result", 64'(bus.W_mul_result), 64'd9);
    applyStimulus(32'd6, 32'd6, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
    step();
    checkOutput("flush_stall_w_valid", 64'(bus.W_mul_valid), 64'd0);
    bubble(1'b1, 1'b0);
    step();
    checkOutput("flush_stall_a_valid", 64'(bus.W_mul_valid), 64'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    step();
    reset = 1'b1;
    applyStimulus(32'd7, 32'd7, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("rst_mid_valid", 64'(bus.W_mul_valid), 64'd0);
    checkOutput("rst_mid_result", 64'(bus.W_mul_result), 64'd0);
    checkOutput("rst_mid_dst", 64'(bus.W_dst_regnum), 64'd0);
    reset = 1'b0;
    bubble(1'b1, 1'b0);
    step();
    checkOutput("rst_after1_valid", 64'(bus.W_mul_valid), 64'd0);
    step();
    checkOutput("rst_after2_valid", 64'(bus.W_mul_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
